// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter feeding the SPI slave transmit FIFO from NREQ requesters.
// Optional macro SPI_TX_ARB_PRIO0_EN gives requester 0 fixed priority.
module spi_tx_arbiter #(
    parameter int NREQ      = 3,
    parameter int DW        = 24,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 tx_full,
    output logic                 tx_wr_en,
    output logic [DW-1:0]        tx_data,
    input  logic                 abort,
    output logic [2:0]           grant_id,
    output logic                 busy
);

`ifdef SPI_TX_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef enum logic {IDLE, GRANT} state_e;

    state_e          state_q, state_d;
    logic [2:0]      owner_q, owner_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [7:0]      burst_cnt_q, burst_cnt_d;
    logic            tx_wr_en_q, tx_wr_en_d;
    logic [DW-1:0]   tx_data_q, tx_data_d;

    logic            own_valid;
    logic            own_last;
    logic [DW-1:0]   own_data;
    logic [2:0]      own_next;
    logic            found;
    logic [2:0]      sel;
    logic            accept;
    logic [7:0]      cnt_inc;

    // Mux the current owner's request lines
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        own_next  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == 3'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[i*DW +: DW];
                own_next  = 3'((i + 1) % NREQ);
            end
        end
    end

    // First valid requester at or after rr_ptr in cyclic order
    always_comb begin
        found = 1'b0;
        sel   = '0;
        if (PRIO0 && req_valid[0]) begin
            found = 1'b1;
        end
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req_valid[i] && (!PRIO0 || i != 0) &&
                    i == (int'(rr_ptr_q) + k) % NREQ) begin
                    found = 1'b1;
                    sel   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        tx_wr_en_d  = 1'b0;
        tx_data_d   = tx_data_q;
        req_ready   = '0;
        accept      = 1'b0;
        cnt_inc     = burst_cnt_q + 8'd1;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = GRANT;
                    owner_d     = sel;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                // Abort withdraws ready so no word is lost to a cancelled accept
                for (int i = 0; i < NREQ; i++) begin
                    if (owner_q == 3'(i)) req_ready[i] = !tx_full && !abort;
                end
                accept = own_valid && !tx_full && !abort;
                if (abort) begin
                    state_d = IDLE;
                    if (!(PRIO0 && owner_q == 3'd0)) rr_ptr_d = own_next;
                end else if (accept) begin
                    tx_wr_en_d  = 1'b1;
                    tx_data_d   = own_data;
                    burst_cnt_d = cnt_inc;
                    if (own_last || cnt_inc == 8'(MAX_BURST)) begin
                        state_d = IDLE;
                        if (!(PRIO0 && owner_q == 3'd0)) rr_ptr_d = own_next;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            tx_wr_en_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            tx_wr_en_q  <= tx_wr_en_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign busy     = (state_q == GRANT);
    assign grant_id = busy ? owner_q : 3'd0;
    assign tx_wr_en = tx_wr_en_q;
    assign tx_data  = tx_data_q;

endmodule
